// File: rtl/mux_stream_arb.sv
// N-channel registered stream mux, fixed-select or round-robin; optional STAT_CNT_EN adds xfer_cnt.
// Latency: 1 cycle from input accept to out_valid; full throughput of 1 beat/cycle.
// Backpressure: out_valid & !out_ready holds the output register and drops every in_ready.
module mux_stream_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
`ifdef STAT_CNT_EN
    ,
    output logic [CNT_W-1:0]   xfer_cnt
`endif
);

    // Channel index must cover exactly N channels; counter needs at least one bit.
    if (SELW != $clog2(N) || N < 2 || CNT_W < 1) begin : g_param_chk
        $error("mux_stream_arb: bad parameters");
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic             g_ok;
    int               gidx;
    int               idx;
    logic             accept;

    // Grant: fixed select (only if in range) or first valid channel from rr_ptr, wrapping at N.
    always_comb begin
        g_ok = 1'b0;
        gidx = 0;
        idx  = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                g_ok = 1'b1;
                gidx = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!g_ok && in_valid[idx]) begin
                    g_ok = 1'b1;
                    gidx = idx;
                end
            end
        end
    end

    // Ready to the granted channel only when the output stage can load; silent in reset.
    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = '0;
        if (rst_n && load_en && g_ok) in_ready[gidx] = 1'b1;
        accept   = load_en && g_ok && in_valid[gidx];
    end

    // Next state for the output register and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = in_data[gidx*WIDTH +: WIDTH];
                out_chan_d = SELW'(gidx);
                if (mode) rr_ptr_d = (gidx == N - 1) ? '0 : SELW'(gidx + 1);
            end
        end
    end

    // State registers; a held beat is discarded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

`ifdef STAT_CNT_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Count beats leaving the output register; wraps naturally.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid_q && out_ready) xfer_cnt_d = xfer_cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt_q <= '0;
        else        xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb: an 8-channel instance plus a 6-channel one for out-of-range select.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants.
module tb_mux_stream_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_chan;

    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [2:0]  sel6;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic [2:0]  out_chan6;

`ifdef STAT_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt6;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_stream_arb #(.WIDTH(8), .N(8), .SELW(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
`ifdef STAT_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    mux_stream_arb #(.WIDTH(8), .N(6), .SELW(3), .CNT_W(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .mode(mode), .sel(sel6), .out_data(out_data6),
        .out_valid(out_valid6), .out_ready(out_ready), .out_chan(out_chan6)
`ifdef STAT_CNT_EN
        , .xfer_cnt(xfer_cnt6)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
    endtask

    // Watchdog: the bench is purely directed, this only guards against a stuck simulator.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(i * 17);
        for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'(i * 17);
        in_valid  = 8'hFF;
        in_valid6 = 6'h3F;
        mode      = 1'b0;
        sel       = 3'd3;
        sel6      = 3'd2;
        out_ready = 1'b1;

        // Reset state: everything cleared, no ready while in reset.
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        step();
        rst_n = 1'b1;

        // Fixed select channel 3.
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'h08);
        step();
        chk("fix_out_data", 32'(out_data), 32'h33);
        chk("fix_out_chan", 32'(out_chan), 32'h3);
        chk("fix_out_valid", 32'(out_valid), 32'h1);

        // Round-robin, all valid, pointer from reset: 0..7 then 0.
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr_all_%0d", i), 32'(out_chan), 32'(i % 8));
        end
        chk("rr_all_data", 32'(out_data), 32'h00);

        // Round-robin skipping idle channels, pointer moved to 6 via a channel-5 grant.
        do_reset();
        mode = 1'b1;
        in_valid = 8'h20;
        step();
        chk("rr_seed_chan", 32'(out_chan), 32'h5);
        in_valid = 8'h24;
        step(); chk("rr_sparse_0", 32'(out_chan), 32'h2);
        step(); chk("rr_sparse_1", 32'(out_chan), 32'h5);
        step(); chk("rr_sparse_2", 32'(out_chan), 32'h2);
        step(); chk("rr_sparse_3", 32'(out_chan), 32'h5);
        chk("rr_sparse_data", 32'(out_data), 32'h55);

        // Backpressure hold, then simultaneous drain and load.
        do_reset();
        mode = 1'b0;
        sel = 3'd1;
        in_valid = 8'hFF;
        in_data[15:8] = 8'hA5;
        step();
        chk("bp_load", 32'(out_data), 32'hA5);
        out_ready = 1'b0;
        in_data[15:8] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h00);
            step();
            chk($sformatf("bp_hold_data_%0d", i), 32'(out_data), 32'hA5);
            chk($sformatf("bp_hold_vld_%0d", i), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h02);
        step();
        chk("bp_next_data", 32'(out_data), 32'h5A);
        chk("bp_next_vld", 32'(out_valid), 32'h1);

        // Out-of-range select on the 6-channel instance.
        do_reset();
        mode = 1'b0;
        sel6 = 3'd2;
        step();
        chk("n6_load_vld", 32'(out_valid6), 32'h1);
        chk("n6_load_data", 32'(out_data6), 32'h22);
        sel6 = 3'd7;
        #1;
        chk("n6_sel7_rdy", 32'(in_ready6), 32'h00);
        step();
        chk("n6_drain_vld", 32'(out_valid6), 32'h0);
        chk("n6_keep_data", 32'(out_data6), 32'h22);

        // Reset mid-stream in round-robin mode (pointer at 3 before reset).
        do_reset();
        in_data[15:8] = 8'h11;
        mode = 1'b1;
        in_valid = 8'hFF;
        step(); step(); step();
        chk("mid_pre_chan", 32'(out_chan), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'h0);
        chk("mid_rst_chan", 32'(out_chan), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_ptr_zero", 32'(out_chan), 32'h0);

`ifdef STAT_CNT_EN
        // Ten beats leave the output register, then reset clears the count.
        do_reset();
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        chk("cnt_ten", 32'(xfer_cnt), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", 32'(xfer_cnt), 32'd0);
        step();
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
